// File: rtl/magma_ctrl.sv
// magma_ctrl: request/response sequencer around a 128-bit block cipher core.
// Accepts one job at a time, launches the core with a one-cycle start pulse,
// waits for a rising edge of core_done, and holds the result until consumed.
// Optional watchdog: define MAGMA_CTRL_TIMEOUT_EN to abort a job whose core
// never completes within TIMEOUT_CYCLES WAIT cycles (sets sticky err).
module magma_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int NAME_W         = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [127:0]      req_data,
    input  logic [127:0]      req_key,
    input  logic [NAME_W-1:0] req_tag,
    output logic              core_start,
    output logic [127:0]      core_data,
    output logic [127:0]      core_key,
    input  logic              core_done,
    input  logic [127:0]      core_result,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [127:0]      res_data,
    output logic [NAME_W-1:0] res_tag,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t            state_q, state_d;
    logic [127:0]      coreData_q, coreData_d;
    logic [127:0]      coreKey_q, coreKey_d;
    logic [127:0]      resData_q, resData_d;
    logic [NAME_W-1:0] tag_q, tag_d;
    logic              resValid_q, resValid_d;
    logic              donePrev_q;
    logic              doneRise;
    logic              errFlag;

`ifdef MAGMA_CTRL_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;

    assign errFlag = err_q;
`else
    assign errFlag = 1'b0;
`endif

    // Completion is an edge, so a done level left over from a previous job is ignored.
    assign doneRise   = core_done & ~donePrev_q;

    assign req_ready  = (state_q == IDLE) & ~errFlag;
    assign core_start = (state_q == LAUNCH);
    assign busy       = (state_q != IDLE);
    assign core_data  = coreData_q;
    assign core_key   = coreKey_q;
    assign res_valid  = resValid_q;
    assign res_data   = resData_q;
    assign res_tag    = tag_q;
    assign err        = errFlag;

    // Next-state and job-register update logic for the four-state sequencer.
    always_comb begin
        state_d    = state_q;
        coreData_d = coreData_q;
        coreKey_d  = coreKey_q;
        resData_d  = resData_q;
        tag_d      = tag_q;
        resValid_d = resValid_q;
`ifdef MAGMA_CTRL_TIMEOUT_EN
        timer_d    = timer_q;
        err_d      = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready) begin
                    coreData_d = req_data;
                    coreKey_d  = req_key;
                    tag_d      = req_tag;
                    state_d    = LAUNCH;
                end
            end
            LAUNCH: begin
`ifdef MAGMA_CTRL_TIMEOUT_EN
                timer_d = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (doneRise) begin
                    resData_d  = core_result;
                    resValid_d = 1'b1;
                    state_d    = HOLD;
                end
`ifdef MAGMA_CTRL_TIMEOUT_EN
                else if (timer_q == TIMER_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            HOLD: begin
                if (res_ready) begin
                    resValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and job registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            coreData_q <= '0;
            coreKey_q  <= '0;
            resData_q  <= '0;
            tag_q      <= '0;
            resValid_q <= 1'b0;
            donePrev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            coreData_q <= coreData_d;
            coreKey_q  <= coreKey_d;
            resData_q  <= resData_d;
            tag_q      <= tag_d;
            resValid_q <= resValid_d;
            donePrev_q <= core_done;
        end
    end

`ifdef MAGMA_CTRL_TIMEOUT_EN
    // Watchdog counter and sticky error flag; only reset clears err.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer_q <= '0;
            err_q   <= 1'b0;
        end else begin
            timer_q <= timer_d;
            err_q   <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_magma_ctrl.sv
// tb_magma_ctrl: directed, scoreboard-based bench for magma_ctrl.
// Covers the timeout path when MAGMA_CTRL_TIMEOUT_EN is defined.
module tb_magma_ctrl;

    localparam int NAME_W = 2;

    localparam logic [127:0] D1 = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
    localparam logic [127:0] K1 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    localparam logic [127:0] R1 = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_ABCD;
    localparam logic [127:0] D2 = 128'hA5A5_A5A5_5A5A_5A5A_A5A5_A5A5_5A5A_5A5A;
    localparam logic [127:0] K2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] R2 = 128'hDEAD_BEEF_CAFE_BABE_0123_4567_89AB_CDEF;
    localparam logic [127:0] D3 = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    localparam logic [127:0] K3 = 128'hC3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3C3;
    localparam logic [127:0] R3 = 128'h7777_0000_7777_0000_7777_0000_7777_0001;
    localparam logic [127:0] D4 = 128'h4444_4444_4444_4444_4444_4444_4444_4444;
    localparam logic [127:0] K4 = 128'hB4B4_B4B4_B4B4_B4B4_B4B4_B4B4_B4B4_B4B4;
    localparam logic [127:0] R4 = 128'h8888_1111_8888_1111_8888_1111_8888_1112;
    localparam logic [127:0] D5 = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    localparam logic [127:0] K5 = 128'hA5A5_0000_A5A5_0000_A5A5_0000_A5A5_0000;
    localparam logic [127:0] R5 = 128'h9999_9999_9999_9999_9999_9999_9999_9999;
    localparam logic [127:0] D6 = 128'h6666_6666_6666_6666_6666_6666_6666_6666;
    localparam logic [127:0] K6 = 128'h9696_9696_9696_9696_9696_9696_9696_9696;
    localparam logic [127:0] R6 = 128'hABAB_CDCD_EFEF_0101_2323_4545_6767_8989;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [127:0]      req_data;
    logic [127:0]      req_key;
    logic [NAME_W-1:0] req_tag;
    logic              core_start;
    logic [127:0]      core_data;
    logic [127:0]      core_key;
    logic              core_done;
    logic [127:0]      core_result;
    logic              res_valid;
    logic              res_ready;
    logic [127:0]      res_data;
    logic [NAME_W-1:0] res_tag;
    logic              busy;
    logic              err;

    typedef struct packed {
        logic [127:0]      data;
        logic [NAME_W-1:0] tag;
    } exp_t;

    exp_t expQ[$];
    int   total       = 0;
    int   bad         = 0;
    int   validCycles = 0;

    magma_ctrl #(
        .TIMEOUT_CYCLES(16),
        .NAME_W        (NAME_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_key    (req_key),
        .req_tag    (req_tag),
        .core_start (core_start),
        .core_data  (core_data),
        .core_key   (core_key),
        .core_done  (core_done),
        .core_result(core_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .busy       (busy),
        .err        (err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock: the scoreboard samples mid-cycle, then returns just after the rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (res_valid === 1'b1) validCycles++;
        if (res_valid === 1'b1 && res_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_result", 128'(res_valid), 128'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sb_res_data", res_data, e.data);
                checkOutput("sb_res_tag", 128'(res_tag), 128'(e.tag));
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Present a job, wait (bounded) for acceptance, and return in the LAUNCH cycle.
    task automatic applyStimulus(input logic [127:0] data, input logic [127:0] key,
                                 input logic [NAME_W-1:0] tag, input logic [127:0] result,
                                 input bit expectRes);
        int n = 0;
        exp_t e;
        req_valid = 1'b1;
        req_data  = data;
        req_key   = key;
        req_tag   = tag;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checkOutput("accept_ready", 128'(req_ready), 128'd1);
        if (expectRes) begin
            e.data = result;
            e.tag  = tag;
            expQ.push_back(e);
        end
        tick();
        req_valid = 1'b0;
        checkOutput("launch_start", 128'(core_start), 128'd1);
        checkOutput("launch_data", core_data, data);
        checkOutput("launch_key", core_key, key);
        checkOutput("launch_busy", 128'(busy), 128'd1);
    endtask

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_data    = '0;
        req_key     = '0;
        req_tag     = '0;
        core_done   = 1'b0;
        core_result = '0;
        res_ready   = 1'b1;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_res_valid", 128'(res_valid), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_err", 128'(err), 128'd0);
        checkOutput("rst_core_start", 128'(core_start), 128'd0);
        checkOutput("rst_res_data", res_data, 128'd0);
        checkOutput("rst_core_data", core_data, 128'd0);
        checkOutput("rst_core_key", core_key, 128'd0);
        reset = 1'b1;
        checkOutput("ready_after_release", 128'(req_ready), 128'd1);

        $display("[TB] basic job, done two cycles after start");
        validCycles = 0;
        applyStimulus(D1, K1, 2'b10, R1, 1'b1);
        tick();
        checkOutput("start_one_cycle", 128'(core_start), 128'd0);
        tick();
        core_done   = 1'b1;
        core_result = R1;
        tick();
        checkOutput("a_res_valid", 128'(res_valid), 128'd1);
        checkOutput("a_res_data", res_data, R1);
        checkOutput("a_res_tag", 128'(res_tag), 128'd2);
        tick();
        checkOutput("a_valid_cleared", 128'(res_valid), 128'd0);
        checkOutput("a_idle", 128'(busy), 128'd0);
        tick();
        checkOutput("a_valid_one_cycle", 128'(validCycles), 128'd1);
        core_done = 1'b0;

        $display("[TB] minimum latency");
        applyStimulus(D2, K2, 2'b01, R2, 1'b1);
        tick();
        core_done   = 1'b1;
        core_result = R2;
        checkOutput("lat_not_early", 128'(res_valid), 128'd0);
        tick();
        checkOutput("lat_3cyc", 128'(res_valid), 128'd1);
        tick();
        core_done = 1'b0;
        tick();

        $display("[TB] hold with backpressure, request during WAIT");
        res_ready = 1'b0;
        applyStimulus(D3, K3, 2'b01, R3, 1'b1);
        tick();
        req_valid = 1'b1;
        req_data  = D4;
        req_key   = K4;
        req_tag   = 2'b11;
        tick();
        tick();
        checkOutput("wait_core_data", core_data, D3);
        checkOutput("wait_core_key", core_key, K3);
        core_done   = 1'b1;
        core_result = R3;
        tick();
        core_result = ~R3;
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_valid", 128'(res_valid), 128'd1);
            checkOutput("hold_data", res_data, R3);
            checkOutput("hold_tag", 128'(res_tag), 128'd1);
            checkOutput("hold_req_ready", 128'(req_ready), 128'd0);
            checkOutput("hold_busy", 128'(busy), 128'd1);
            checkOutput("hold_core_data", core_data, D3);
            tick();
        end
        res_ready = 1'b1;
        checkOutput("hs_no_ready", 128'(req_ready), 128'd0);
        tick();
        checkOutput("post_hs_valid", 128'(res_valid), 128'd0);
        checkOutput("post_hs_core_data", core_data, D3);

        $display("[TB] done level held across jobs");
        applyStimulus(D4, K4, 2'b11, R4, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("held_done_ignored", 128'(res_valid), 128'd0);
        end
        core_done   = 1'b0;
        core_result = R4;
        tick();
        core_done = 1'b1;
        tick();
        checkOutput("redone_valid", 128'(res_valid), 128'd1);
        checkOutput("redone_data", res_data, R4);
        tick();
        core_done = 1'b0;

        $display("[TB] reset during WAIT");
        applyStimulus(D5, K5, 2'b00, R5, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        checkOutput("midrst_busy", 128'(busy), 128'd0);
        checkOutput("midrst_core_data", core_data, 128'd0);
        checkOutput("midrst_core_key", core_key, 128'd0);
        checkOutput("midrst_res_data", res_data, 128'd0);
        checkOutput("midrst_res_tag", 128'(res_tag), 128'd0);
        reset = 1'b1;
        tick();
        core_done   = 1'b1;
        core_result = R5;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("abandon_no_valid", 128'(res_valid), 128'd0);
            checkOutput("abandon_ready", 128'(req_ready), 128'd1);
        end
        core_done = 1'b0;
        tick();

`ifdef MAGMA_CTRL_TIMEOUT_EN
        $display("[TB] watchdog timeout");
        applyStimulus(D6, K6, 2'b10, R6, 1'b0);
        tick();
        repeat (15) tick();
        checkOutput("to_not_yet_err", 128'(err), 128'd0);
        checkOutput("to_not_yet_busy", 128'(busy), 128'd1);
        tick();
        checkOutput("to_err", 128'(err), 128'd1);
        checkOutput("to_idle", 128'(busy), 128'd0);
        checkOutput("to_ready_low", 128'(req_ready), 128'd0);
        req_valid = 1'b1;
        req_data  = D1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("to_sticky_ready", 128'(req_ready), 128'd0);
            checkOutput("to_sticky_busy", 128'(busy), 128'd0);
            checkOutput("to_sticky_err", 128'(err), 128'd1);
        end
        core_done = 1'b1;
        tick();
        tick();
        checkOutput("to_no_result", 128'(res_valid), 128'd0);
        core_done = 1'b0;
        req_valid = 1'b0;
        reset     = 1'b0;
        tick();
        reset = 1'b1;
        checkOutput("to_err_cleared", 128'(err), 128'd0);
        checkOutput("to_ready_back", 128'(req_ready), 128'd1);
        tick();
`else
        $display("[TB] no watchdog: WAIT persists");
        applyStimulus(D6, K6, 2'b10, R6, 1'b1);
        repeat (40) tick();
        checkOutput("nto_busy", 128'(busy), 128'd1);
        checkOutput("nto_err", 128'(err), 128'd0);
        checkOutput("nto_no_valid", 128'(res_valid), 128'd0);
        core_done   = 1'b1;
        core_result = R6;
        tick();
        checkOutput("nto_valid", 128'(res_valid), 128'd1);
        tick();
        core_done = 1'b0;
        tick();
`endif

        repeat (2) tick();
        checkOutput("scoreboard_empty", 128'(expQ.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magma_ctrl.md
MAGMA_CTRL -- requirements
Module: magma_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum wait, in cycles, for core completion.
REQ-002 Parameter NAME_W, default 2: width of the requester tag.
REQ-003 Port clk  in  1  clock; all logic on rising edge.
REQ-004 Port reset  in  1  synchronous, active-low reset.
REQ-005 Port req_valid  in  1  requester presents a job.
REQ-006 Port req_ready  out  1  controller accepts the job this cycle.
REQ-007 Port req_data  in  128  plaintext block.
REQ-008 Port req_key  in  128  key.
REQ-009 Port req_tag  in  NAME_W  requester tag, returned with the result.
REQ-010 Port core_start  out  1  one-cycle start pulse to the cipher core.
REQ-011 Port core_data  out  128  registered operand to the core.
REQ-012 Port core_key  out  128  registered key to the core.
REQ-013 Port core_done  in  1  core finished; level or pulse.
REQ-014 Port core_result  in  128  core ciphertext.
REQ-015 Port res_valid  out  1  result available.
REQ-016 Port res_ready  in  1  consumer takes the result.
REQ-017 Port res_data  out  128  captured ciphertext.
REQ-018 Port res_tag  out  NAME_W  tag of the job that produced res_data.
REQ-019 Port busy  out  1  high in every state except IDLE.
REQ-020 Port err  out  1  sticky timeout flag.

Function
REQ-021 The FSM SHALL have four states: IDLE, LAUNCH, WAIT, HOLD.
REQ-022 req_ready SHALL be high only in IDLE, and only when err is low.
REQ-023 On req_valid & req_ready, the block SHALL latch req_data, req_key and req_tag into core_data, core_key and the tag register, then go to LAUNCH.
REQ-024 LAUNCH SHALL last exactly one cycle, assert core_start for that cycle only, and go to WAIT.
REQ-025 In WAIT, the block SHALL detect completion only on a rising edge of core_done (sampled previous value low, current value high).
- A core_done level still high from a prior job SHALL be ignored.
REQ-026 On detected completion, the block SHALL capture core_result into res_data in that same cycle, set res_valid on the next cycle, and go to HOLD.
REQ-027 Minimum latency SHALL be 3 cycles, measured from the accept edge to the first cycle of res_valid, with core_done rising in the first WAIT cycle.
REQ-028 In HOLD, res_valid, res_data and res_tag SHALL stay stable until res_valid & res_ready.
- On that handshake: clear res_valid and go to IDLE.
REQ-029 A new job SHALL NOT be accepted in the cycle res_valid clears; the earliest accept is the following cycle.
REQ-030 core_data and core_key SHALL hold their value from LAUNCH until the next accept.
REQ-031 The block SHALL ignore req_valid while busy, and SHALL NOT modify any job state in response.
REQ-032 The block SHALL ignore core_done in IDLE, LAUNCH and HOLD.

Reset
REQ-033 While reset is low at a clock edge, the block SHALL:
- set state to IDLE;
- clear core_start, res_valid, busy and err;
- clear res_data, res_tag, core_data, core_key and the timeout counter to zero.
REQ-034 Reset asserted mid-job SHALL abandon the job; a core_done arriving after reset release SHALL be ignored.
REQ-035 req_ready SHALL be high in the first cycle after reset release.

Configuration
REQ-036 With macro MAGMA_CTRL_TIMEOUT_EN defined, the block SHALL include a watchdog:
- the counter clears on entry to WAIT and increments each WAIT cycle;
- when the counter reaches TIMEOUT_CYCLES without completion, the block sets err, goes to IDLE and produces no result;
- err clears only on reset, and req_ready stays low while err is set.
REQ-037 Without MAGMA_CTRL_TIMEOUT_EN, the block SHALL have no counter and SHALL hold err at 0, and WAIT SHALL persist until completion.

Verification
REQ-038 Accept, then core_done rises 2 cycles after core_start with core_result=128'h1234...ABCD, res_ready=1 -> res_valid for exactly 1 cycle, carrying that value and req_tag=2'b10.
REQ-039 Hold res_ready=0 for 10 cycles after res_valid -> res_data stable; req_ready=0 throughout; busy=1.
REQ-040 Hold core_done=1 continuously across two jobs -> second job completes only after core_done drops and rises again.
REQ-041 Pulse reset low during WAIT, then raise core_done 1 cycle after release -> no res_valid; req_ready=1.
REQ-042 With TIMEOUT_EN defined and TIMEOUT_CYCLES=16, core_done held at 0 -> err=1 after 16 WAIT cycles; req_ready stays 0 until reset.
REQ-043 Hold req_valid high with new data during WAIT -> core_data unchanged; that data is accepted only after the HOLD handshake.
